// File: rtl/wfg_drive_pat_pkg.sv
// Shared definitions for the waveform generator pattern drive stage:
// register offsets, control bit positions and the per-channel mode mapping.
package wfg_drive_pat_pkg;

  // Byte offsets of the registers; bits [3:2] select the register.
  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_PATSEL = 4'h4;
  localparam logic [3:0] ADDR_STATUS = 4'h8;

  // CTRL register layout.
  localparam int CTRL_EN = 0;
  localparam int CTRL_OE = 1;
  localparam int CTRL_W  = 2;

  // Per-channel pattern mode held in PATSEL.
  typedef enum logic [1:0] {
    PAT_LOW  = 2'd0,
    PAT_HIGH = 2'd1,
    PAT_DATA = 2'd2,
    PAT_INV  = 2'd3
  } pat_mode_e;

  // Value driven for one channel given its mode and the stored sample bit.
  function automatic logic pat_map(input logic [1:0] mode, input logic sample_bit);
    logic result;
    case (pat_mode_e'(mode))
      PAT_LOW:  result = 1'b0;
      PAT_HIGH: result = 1'b1;
      PAT_DATA: result = sample_bit;
      default:  result = ~sample_bit;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/wfg_drive_pat_wishbone.sv
// Wishbone classic slave for the pattern drive stage: CTRL/PATSEL registers,
// sticky UNDERRUN flag with write-1-to-clear, single-cycle ack and read mux.
module wfg_drive_pat_wishbone
  import wfg_drive_pat_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              cyc,
  input  logic              stb,
  input  logic              we,
  input  logic [3:0]        sel,
  input  logic [3:0]        adr,
  input  logic [31:0]       wdata,
  output logic              ack,
  output logic [31:0]       rdata,
  input  logic              underrun_set,
  input  logic [CNT_W-1:0]  count,
  output logic [CTRL_W-1:0] ctrl,
  output logic [31:0]       patsel
);

  logic              ack_reg;
  logic [31:0]       rdata_reg;
  logic [31:0]       rdata_next;
  logic [CTRL_W-1:0] ctrl_reg;
  logic [31:0]       patsel_reg;
  logic [31:0]       patsel_next;
  logic              underrun_reg;
  logic              access;
  logic              wr_ctrl;
  logic              wr_patsel;
  logic              wr_status;
  logic              underrun_clr;
  logic              unused_adr;

  // A new access is taken only while ack is low, so every transfer costs two
  // cycles and ack is a one-cycle pulse.
  assign access    = cyc & stb & ~ack_reg;
  assign wr_ctrl   = access & we & (adr[3:2] == ADDR_CTRL[3:2]);
  assign wr_patsel = access & we & (adr[3:2] == ADDR_PATSEL[3:2]);
  assign wr_status = access & we & (adr[3:2] == ADDR_STATUS[3:2]);

  assign underrun_clr = wr_status & sel[0] & wdata[0];
  assign unused_adr   = ^adr[1:0];

  // Byte-lane merge for PATSEL writes.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_patsel_byte
      assign patsel_next[8*gi +: 8] = (wr_patsel & sel[gi]) ? wdata[8*gi +: 8]
                                                            : patsel_reg[8*gi +: 8];
    end
  endgenerate

  // Read mux; the reserved slot at 0xC reads as zero.
  always_comb begin
    rdata_next = '0;
    case (adr[3:2])
      ADDR_CTRL[3:2]:   rdata_next[CTRL_W-1:0] = ctrl_reg;
      ADDR_PATSEL[3:2]: rdata_next = patsel_reg;
      ADDR_STATUS[3:2]: begin
        rdata_next[0]          = underrun_reg;
        rdata_next[16 +: CNT_W] = count;
      end
      default:          rdata_next = '0;
    endcase
  end

  // Register file, ack pulse and registered read data. A new underrun in the
  // same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (srst) begin
      ack_reg      <= 1'b0;
      rdata_reg    <= '0;
      ctrl_reg     <= '0;
      patsel_reg   <= '0;
      underrun_reg <= 1'b0;
    end else begin
      ack_reg      <= access;
      rdata_reg    <= (access & ~we) ? rdata_next : '0;
      patsel_reg   <= patsel_next;
      underrun_reg <= (underrun_reg & ~underrun_clr) | underrun_set;
      if (wr_ctrl & sel[0]) begin
        ctrl_reg <= wdata[CTRL_W-1:0];
      end
    end
  end

  assign ack    = ack_reg;
  assign rdata  = rdata_reg;
  assign ctrl   = ctrl_reg;
  assign patsel = patsel_reg;

endmodule

// File: rtl/wfg_drive_pat.sv
// Output stage of the waveform generator: accepts sync-paced samples over a
// valid/ready stream, maps each bit through its channel mode and drives the
// registered pattern and output enables towards the IO pins.
module wfg_drive_pat
  import wfg_drive_pat_pkg::*;
#(
  parameter int CHANNELS = 16,
  parameter int CNT_W    = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [3:0]          wbs_adr_i,
  input  logic [31:0]         wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  input  logic                wfg_pat_sync_i,
  input  logic [31:0]         wfg_pat_data_i,
  input  logic                wfg_pat_valid_i,
  output logic                wfg_pat_ready_o,
  output logic [CHANNELS-1:0] pat_o,
  output logic [CHANNELS-1:0] pat_oe_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [CTRL_W-1:0]   ctrl;
  logic [31:0]         patsel;
  logic                en;
  logic                oe;
  logic                xfer;
  logic                underrun_set;
  logic [CHANNELS-1:0] sample_q_reg;
  logic [CNT_W-1:0]    count_reg;
  logic [CHANNELS-1:0] pat_reg;
  logic [CHANNELS-1:0] pat_next;
  logic [CHANNELS-1:0] pat_oe_reg;
  logic                unused_data;

  assign en = ctrl[CTRL_EN];
  assign oe = ctrl[CTRL_OE];

  // Ready follows the current EN so a CTRL write landing on a sync edge
  // still lets that sync through with the old enable.
  assign wfg_pat_ready_o = en & wfg_pat_sync_i;
  assign xfer            = wfg_pat_valid_i & wfg_pat_ready_o;
  assign underrun_set    = wfg_pat_ready_o & ~wfg_pat_valid_i;

  assign unused_data = ^wfg_pat_data_i[31:CHANNELS];

  generate
    if (CHANNELS < 16) begin : g_unused_patsel
      logic unused_patsel;
      assign unused_patsel = ^patsel[31:2*CHANNELS];
    end
  endgenerate

  wfg_drive_pat_wishbone #(
    .CNT_W (CNT_W)
  ) u_wishbone (
    .clk          (wb_clk_i),
    .srst         (wb_rst_i),
    .cyc          (wbs_cyc_i),
    .stb          (wbs_stb_i),
    .we           (wbs_we_i),
    .sel          (wbs_sel_i),
    .adr          (wbs_adr_i),
    .wdata        (wbs_dat_i),
    .ack          (wbs_ack_o),
    .rdata        (wbs_dat_o),
    .underrun_set (underrun_set),
    .count        (count_reg),
    .ctrl         (ctrl),
    .patsel       (patsel)
  );

  // Per-channel mode mapping; a disabled block drives zeros.
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign pat_next[gi] = en ? pat_map(patsel[2*gi +: 2], sample_q_reg[gi]) : 1'b0;
    end
  endgenerate

  // Capture accepted samples and count them; both survive a disable.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sample_q_reg <= '0;
      count_reg    <= '0;
    end else if (xfer) begin
      sample_q_reg <= wfg_pat_data_i[CHANNELS-1:0];
      count_reg    <= count_reg + CNT_ONE;
    end
  end

  // Registered pattern and output enables.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      pat_reg    <= '0;
      pat_oe_reg <= '0;
    end else begin
      pat_reg    <= pat_next;
      pat_oe_reg <= (en & oe) ? '1 : '0;
    end
  end

  assign pat_o    = pat_reg;
  assign pat_oe_o = pat_oe_reg;

endmodule
